// File: rtl/timer_ctrl.sv
// Programmable interval timer: register file, prescaled down-counter with
// IDLE/RUN/DONE sequencing, and a level interrupt held until acknowledged.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; COUNT and prescaler hold their values
// RUN   | prescaler advancing, COUNT decrements on each tick
// DONE  | one-shot expired; COUNT holds 0, EN reads 0
module timer_ctrl #(
    parameter int          PRESC_W    = 16,
    parameter logic [31:0] RESET_LOAD = 32'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic        irq_ack,
    output logic        irq,
    output logic        tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 auto_q, auto_d;
    logic                 ie_q, ie_d;
    logic [31:0]          load_q, load_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [31:0]          count_q, count_d;
    logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic                 pend_q, pend_d;
    logic                 irq_q, irq_d;
    logic                 tick_q, tick_d;
    logic                 ctrl_wr;
    logic                 pend_clr;
    logic                 expire;

    // State and register flops; reset is asynchronous so irq drops at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            auto_q      <= 1'b0;
            ie_q        <= 1'b0;
            load_q      <= RESET_LOAD;
            presc_q     <= '0;
            count_q     <= '0;
            presc_cnt_q <= '0;
            pend_q      <= 1'b0;
            irq_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            auto_q      <= auto_d;
            ie_q        <= ie_d;
            load_q      <= load_d;
            presc_q     <= presc_d;
            count_q     <= count_d;
            presc_cnt_q <= presc_cnt_d;
            pend_q      <= pend_d;
            irq_q       <= irq_d;
            tick_q      <= tick_d;
        end
    end

    // Next-state: sequencing, prescaler/counter, register writes, PEND set/clear.
    always_comb begin
        state_d     = state_q;
        auto_d      = auto_q;
        ie_d        = ie_q;
        load_d      = load_q;
        presc_d     = presc_q;
        count_d     = count_q;
        presc_cnt_d = presc_cnt_q;
        pend_d      = pend_q;
        tick_d      = 1'b0;
        irq_d       = pend_q & ie_q;
        expire      = 1'b0;
        ctrl_wr     = we && (addr == 3'd0);
        pend_clr    = irq_ack || (we && (addr == 3'd4) && wd[0]);

        case (state_q)
            S_RUN: begin
                // A stop write takes priority over any tick on the same edge.
                if (ctrl_wr && !wd[0]) begin
                    state_d = S_IDLE;
                end else if (presc_cnt_q == presc_q) begin
                    presc_cnt_d = '0;
                    tick_d      = 1'b1;
                    if (count_q == 32'd0) begin
                        expire = 1'b1;
                        if (auto_q) begin
                            count_d = load_q;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + 1'b1;
                end
            end
            default: begin
                if (ctrl_wr && wd[0]) begin
                    state_d     = S_RUN;
                    count_d     = load_q;
                    presc_cnt_d = '0;
                end
            end
        endcase

        if (ctrl_wr) begin
            auto_d = wd[1];
            ie_d   = wd[2];
        end
        if (we && (addr == 3'd1)) begin
            load_d = wd;
        end
        if (we && (addr == 3'd2)) begin
            presc_d = wd[PRESC_W-1:0];
        end

        // Expiry beats a same-edge acknowledge so no event is lost.
        if (expire) begin
            pend_d = 1'b1;
        end else if (pend_clr) begin
            pend_d = 1'b0;
        end
    end

    // Register read mux; EN is exactly "currently running".
    always_comb begin
        rd = 32'd0;
        case (addr)
            3'd0:    rd = {29'd0, ie_q, auto_q, (state_q == S_RUN)};
            3'd1:    rd = load_q;
            3'd2:    rd = 32'(presc_q);
            3'd3:    rd = count_q;
            3'd4:    rd = {31'd0, pend_q};
            default: rd = 32'd0;
        endcase
    end

    assign irq  = irq_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with hand-computed expectations,
// then randomized traffic, all cross-checked each cycle against a model.
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  addr = 3'd0;
    logic        we = 1'b0;
    logic [31:0] wd = 32'd0;
    logic        irq_ack = 1'b0;
    logic [31:0] rd;
    logic        irq;
    logic        tick;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference model state
    bit          m_run, m_auto, m_ie, m_pend, m_irq, m_tick;
    logic [31:0] m_load, m_count;
    logic [15:0] m_presc, m_pc;

    timer_ctrl #(.PRESC_W(16), .RESET_LOAD(32'd100)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wd      (wd),
        .rd      (rd),
        .irq_ack (irq_ack),
        .irq     (irq),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {29'd0, m_ie, m_auto, m_run};
            3'd1:    return m_load;
            3'd2:    return {16'd0, m_presc};
            3'd3:    return m_count;
            3'd4:    return {31'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_run = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_irq = 0; m_tick = 0;
        m_load = 32'd100; m_count = 32'd0; m_presc = 16'd0; m_pc = 16'd0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic m_step();
        bit          ctrl_wr  = we && (addr == 3'd0);
        bit          exp      = 0;
        bit          tk       = 0;
        bit          old_pend = m_pend;
        bit          old_ie   = m_ie;
        logic [31:0] old_load = m_load;
        if (m_run) begin
            if (ctrl_wr && !wd[0]) begin
                m_run = 0;
            end else if (m_pc == m_presc) begin
                m_pc = 16'd0;
                tk = 1;
                if (m_count == 32'd0) begin
                    exp = 1;
                    if (m_auto) m_count = old_load;
                    else        m_run = 0;
                end else begin
                    m_count = m_count - 32'd1;
                end
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end else if (ctrl_wr && wd[0]) begin
            m_run = 1;
            m_count = old_load;
            m_pc = 16'd0;
        end
        if (ctrl_wr) begin
            m_auto = wd[1];
            m_ie = wd[2];
        end
        if (we && addr == 3'd1) m_load = wd;
        if (we && addr == 3'd2) m_presc = wd[15:0];
        if (exp) m_pend = 1;
        else if (irq_ack || (we && addr == 3'd4 && wd[0])) m_pend = 0;
        m_irq = old_pend && old_ie;
        m_tick = tk;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset && chk_on) begin
            check("rd", rd, m_read(addr));
            check("irq", 32'(irq), 32'(m_irq));
            check("tick", 32'(tick), 32'(m_tick));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        m_step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; we = 1'b1; wd = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rd, exp);
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        rd_chk("rst_ctrl", 3'd0, 32'd0);
        rd_chk("rst_load", 3'd1, 32'd100);
        rd_chk("rst_count", 3'd3, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        chk_on = 1'b1;

        // 1: one-shot, LOAD=3 PRESC=1 -> expiry 8 clocks after enable
        wr(3'd1, 32'd3);
        wr(3'd2, 32'd1);
        wr(3'd0, 32'h5);                 // T0
        addr = 3'd3;
        cyc(); check("t1_tick_T1", 32'(tick), 32'd0); check("t1_cnt_T1", rd, 32'd3);
        cyc(); check("t1_tick_T2", 32'(tick), 32'd1); check("t1_cnt_T2", rd, 32'd2);
        cyc(); check("t1_tick_T3", 32'(tick), 32'd0);
        cyc(); check("t1_cnt_T4", rd, 32'd1);
        cyc();
        cyc(); check("t1_cnt_T6", rd, 32'd0);
        cyc();
        addr = 3'd4;
        cyc(); check("t1_pend_T8", rd, 32'd1); check("t1_irq_T8", 32'(irq), 32'd0);
        cyc(); check("t1_irq_T9", 32'(irq), 32'd1);
        rd_chk("t1_ctrl_done", 3'd0, 32'h4);

        // 2: auto-reload every 3 clocks; W1C on expiry edge loses to set
        wr(3'd1, 32'd2);
        wr(3'd2, 32'd0);
        wr(3'd4, 32'd1);
        wr(3'd0, 32'h7);                 // T0
        cyc(); cyc(); cyc();             // T3 expiry
        wr(3'd4, 32'd1);                 // T4 non-expiry clear
        check("t2_clr", rd, 32'd0);
        cyc(); check("t2_irq_low", 32'(irq), 32'd0);
        wr(3'd4, 32'd1);                 // T6 expiry + clear
        check("t2_set_wins", rd, 32'd1);

        // 3: stop at COUNT=5, hold, restart reloads LOAD
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd1);
        wr(3'd1, 32'd9);
        wr(3'd0, 32'd1);                 // T0
        repeat (4) cyc();
        rd_chk("t3_cnt5", 3'd3, 32'd5);
        wr(3'd0, 32'd0);
        addr = 3'd3;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("t3_hold", rd, 32'd5);
            check("t3_notick", 32'(tick), 32'd0);
        end
        wr(3'd0, 32'd1);
        rd_chk("t3_reload", 3'd3, 32'd9);

        // 4: masked pending, unmask, hardware ack
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd1);
        wr(3'd1, 32'd1);
        wr(3'd0, 32'd1);
        repeat (3) cyc();
        rd_chk("t4_pend", 3'd4, 32'd1);
        check("t4_masked", 32'(irq), 32'd0);
        wr(3'd0, 32'h4);
        cyc(); check("t4_unmask", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        rd_chk("t4_ack", 3'd4, 32'd0);
        cyc(); check("t4_irq_off", 32'(irq), 32'd0);

        // 5: LOAD change mid-period applies at next reload
        wr(3'd1, 32'd10);
        wr(3'd4, 32'd1);
        wr(3'd0, 32'h7);                 // T0
        cyc(); cyc();
        wr(3'd1, 32'd4);                 // T3
        addr = 3'd4;
        repeat (7) cyc();                // T10
        check("t5_pre", rd, 32'd0);
        cyc(); check("t5_exp1", rd, 32'd1);
        wr(3'd4, 32'd1);                 // T12
        repeat (3) cyc();                // T15
        check("t5_pre2", rd, 32'd0);
        cyc(); check("t5_exp2", rd, 32'd1);
        cyc(); check("t5_irq", 32'(irq), 32'd1);

        // 6: asynchronous reset mid-run
        #2;
        reset = 1'b1;
        #1;
        check("t6_irq_async", 32'(irq), 32'd0);
        m_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        rd_chk("t6_ctrl", 3'd0, 32'd0);
        rd_chk("t6_load", 3'd1, 32'd100);
        rd_chk("t6_count", 3'd3, 32'd0);
        rd_chk("t6_presc", 3'd2, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            addr = 3'($urandom_range(0, 7));
            we = ($urandom_range(0, 5) == 0);
            irq_ack = ($urandom_range(0, 15) == 0);
            case (addr)
                3'd1:    wd = $urandom_range(0, 6);
                3'd2:    wd = ($urandom & 32'hFFFF0000) | $urandom_range(0, 3);
                default: wd = $urandom;
            endcase
            cyc();
        end
        we = 1'b0;
        irq_ack = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
